stage_ctrl: RTL and testbench

Multi-cycle sequencing controller for the CPU core. It steps each instruction through fetch, register read, execute, memory and writeback, and generates the one-cycle stage enables. It sits directly upstream of the register file and drives its `enable_reg_fetch` and `enable_reg_write` strobes. It also handles the instruction/data memory wait handshakes, halt/run control, a memory-wait watchdog and a retired-instruction counter.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/wait_timer.sv | 33 +++
 rtl/stage_ctrl.sv | 106 ++++++++++
 tb/tb_stage_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU core sequencing logic: stage state encoding
// and memory-wait watchdog sizing.
package cpu_pkg;

  localparam logic [2:0] StIdle      = 3'd0;
  localparam logic [2:0] StFetch     = 3'd1;
  localparam logic [2:0] StDecode    = 3'd2;
  localparam logic [2:0] StExecute   = 3'd3;
  localparam logic [2:0] StMemory    = 3'd4;
  localparam logic [2:0] StWriteback = 3'd5;
  localparam logic [2:0] StHalted    = 3'd6;
  localparam logic [2:0] StError     = 3'd7;

  localparam int unsigned TimeoutCyclesDefault = 255;
  localparam int unsigned WdWidth              = 10;

endpackage : cpu_pkg

// File: rtl/wait_timer.sv
// Clear/enable cycle counter; expired_o flags the cycle in which the count of
// consecutive enabled cycles, including the current one, reaches Limit.
module wait_timer
  import cpu_pkg::*;
#(
  parameter int unsigned Width = WdWidth,
  parameter int unsigned Limit = TimeoutCyclesDefault
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [Width-1:0] LastCount = Width'(Limit - 1);
  localparam logic [Width-1:0] One       = {{(Width-1){1'b0}}, 1'b1};

  logic [Width-1:0] r_count;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else if (clr_i) begin
      r_count <= '0;
    end else if (en_i) begin
      r_count <= r_count + One;
    end
  end

  assign expired_o = en_i && (r_count == LastCount);

endmodule : wait_timer

// File: rtl/stage_ctrl.sv
// Multi-cycle instruction sequencer: stage enables, memory wait handshakes,
// halt/run control, memory-wait watchdog and retired-instruction counter.
module stage_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned TimeoutCycles = TimeoutCyclesDefault,
  parameter int unsigned CountSize     = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 halt_req,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  input  logic                 is_load,
  input  logic                 is_store,
  input  logic                 do_reg_write,
  output logic                 enable_fetch,
  output logic                 enable_reg_fetch,
  output logic                 enable_execute,
  output logic                 enable_mem,
  output logic                 enable_reg_write,
  output logic                 enable_pc,
  output logic                 busy,
  output logic                 bus_error,
  output logic [CountSize-1:0] instr_count
);

  localparam logic [CountSize-1:0] CountOne = {{(CountSize-1){1'b0}}, 1'b1};

  logic [2:0]           r_state;
  logic [2:0]           w_state_d;
  logic                 w_retire;
  logic                 w_expired;
  logic                 w_waiting;
  logic                 w_tmr_clr;
  logic [CountSize-1:0] r_instr_count;

  assign w_waiting = (r_state == StFetch) || (r_state == StMemory);
  assign w_tmr_clr = (r_state != w_state_d);

  wait_timer #(
    .Width (WdWidth),
    .Limit (TimeoutCycles)
  ) u_wait_timer (
    .clk_i     (clock),
    .rst_i     (reset),
    .clr_i     (w_tmr_clr),
    .en_i      (w_waiting),
    .expired_o (w_expired)
  );

  // A ready in the expiry cycle takes priority over the watchdog.
  always_comb begin
    w_state_d = r_state;
    w_retire  = 1'b0;
    case (r_state)
      StIdle:      if (run) w_state_d = StFetch;
      StFetch: begin
        if (imem_ready)     w_state_d = StDecode;
        else if (w_expired) w_state_d = StError;
      end
      StDecode:    w_state_d = StExecute;
      StExecute: begin
        if (is_load || is_store) w_state_d = StMemory;
        else if (do_reg_write)   w_state_d = StWriteback;
        else                     w_retire  = 1'b1;
      end
      StMemory: begin
        if (dmem_ready) begin
          if (is_load) w_state_d = StWriteback;
          else         w_retire  = 1'b1;
        end else if (w_expired) begin
          w_state_d = StError;
        end
      end
      StWriteback: w_retire = 1'b1;
      StHalted:    if (run && !halt_req) w_state_d = StFetch;
      StError:     w_state_d = StError;
      default:     w_state_d = StIdle;
    endcase
    if (w_retire) w_state_d = halt_req ? StHalted : StFetch;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= StIdle;
      r_instr_count <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_retire) r_instr_count <= r_instr_count + CountOne;
    end
  end

  assign enable_fetch     = (r_state == StFetch);
  assign enable_reg_fetch = (r_state == StDecode);
  assign enable_execute   = (r_state == StExecute);
  assign enable_mem       = (r_state == StMemory);
  assign enable_reg_write = (r_state == StWriteback);
  assign enable_pc        = w_retire;
  assign busy             = !((r_state == StIdle) || (r_state == StHalted) ||
                              (r_state == StError));
  assign bus_error        = (r_state == StError);
  assign instr_count      = r_instr_count;

endmodule : stage_ctrl

// File: tb/tb_stage_ctrl.sv
// Self-checking bench for stage_ctrl: per-cycle input/expected-output records
// are queued by each scenario and popped as the DUT steps through them.
module tb_stage_ctrl;

  localparam int unsigned CountSize = 32;

  localparam logic [6:0] RUN = 7'b1000000;
  localparam logic [6:0] HLT = 7'b0100000;
  localparam logic [6:0] IMR = 7'b0010000;
  localparam logic [6:0] DMR = 7'b0001000;
  localparam logic [6:0] LD  = 7'b0000100;
  localparam logic [6:0] ST  = 7'b0000010;
  localparam logic [6:0] WR  = 7'b0000001;

  // {fetch, reg_fetch, execute, mem, reg_write, pc, busy, bus_error}
  localparam logic [7:0] O_IDLE = 8'b0000_0000;
  localparam logic [7:0] O_F    = 8'b1000_0010;
  localparam logic [7:0] O_D    = 8'b0100_0010;
  localparam logic [7:0] O_E    = 8'b0010_0010;
  localparam logic [7:0] O_ER   = 8'b0010_0110;
  localparam logic [7:0] O_M    = 8'b0001_0010;
  localparam logic [7:0] O_MR   = 8'b0001_0110;
  localparam logic [7:0] O_W    = 8'b0000_1110;
  localparam logic [7:0] O_ERR  = 8'b0000_0001;

  typedef struct packed {
    logic [6:0] in;
    logic [7:0] exp;
  } cyc_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic run = 1'b0, halt_req = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
  logic is_load = 1'b0, is_store = 1'b0, do_reg_write = 1'b0;
  logic enable_fetch, enable_reg_fetch, enable_execute, enable_mem;
  logic enable_reg_write, enable_pc, busy, bus_error;
  logic [CountSize-1:0] instr_count;
  logic [7:0] obs;

  int   n_total = 0;
  int   n_bad   = 0;
  cyc_t q[$];
  cyc_t c;

  always #5 clock = ~clock;

  assign obs = {enable_fetch, enable_reg_fetch, enable_execute, enable_mem,
                enable_reg_write, enable_pc, busy, bus_error};

  stage_ctrl #(
    .TimeoutCycles (4),
    .CountSize     (CountSize)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .run              (run),
    .halt_req         (halt_req),
    .imem_ready       (imem_ready),
    .dmem_ready       (dmem_ready),
    .is_load          (is_load),
    .is_store         (is_store),
    .do_reg_write     (do_reg_write),
    .enable_fetch     (enable_fetch),
    .enable_reg_fetch (enable_reg_fetch),
    .enable_execute   (enable_execute),
    .enable_mem       (enable_mem),
    .enable_reg_write (enable_reg_write),
    .enable_pc        (enable_pc),
    .busy             (busy),
    .bus_error        (bus_error),
    .instr_count      (instr_count)
  );

  task automatic test_reset();
    #1;
    n_total++;
    if (obs !== O_IDLE) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want %b", obs, O_IDLE);
    end
    n_total++;
    if (instr_count !== '0) begin
      n_bad++;
      $display("FAIL reset_count: got %0h want 0", instr_count);
    end
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_alu();
    int idx = 0;
    q.push_back({RUN,             O_IDLE});
    q.push_back({RUN | IMR | DMR, O_F});
    q.push_back({RUN | IMR | DMR, O_D});
    q.push_back({RUN | WR,        O_E});
    q.push_back({RUN | HLT | WR,  O_W});
    q.push_back({7'b0,            O_IDLE});
    while (q.size() > 0) begin
      c = q.pop_front();
      {run, halt_req, imem_ready, dmem_ready, is_load, is_store, do_reg_write} = c.in;
      #2;
      n_total++;
      if (obs !== c.exp) begin
        n_bad++;
        $display("FAIL alu cyc%0d: got %b want %b", idx, obs, c.exp);
      end
      idx++;
      @(posedge clock); #1;
    end
    n_total++;
    if (instr_count !== 32'd1) begin
      n_bad++;
      $display("FAIL alu_count: got %0d want 1", instr_count);
    end
  endtask

  task automatic test_no_writeback();
    int idx = 0;
    q.push_back({RUN,       O_IDLE});
    q.push_back({RUN | IMR, O_F});
    q.push_back({RUN,       O_D});
    q.push_back({RUN | HLT, O_ER});
    q.push_back({7'b0,      O_IDLE});
    while (q.size() > 0) begin
      c = q.pop_front();
      {run, halt_req, imem_ready, dmem_ready, is_load, is_store, do_reg_write} = c.in;
      #2;
      n_total++;
      if (obs !== c.exp) begin
        n_bad++;
        $display("FAIL no_wb cyc%0d: got %b want %b", idx, obs, c.exp);
      end
      idx++;
      @(posedge clock); #1;
    end
    n_total++;
    if (instr_count !== 32'd2) begin
      n_bad++;
      $display("FAIL no_wb_count: got %0d want 2", instr_count);
    end
  endtask

  // dmem_ready arrives in the 4th MEMORY cycle, exactly at the watchdog limit.
  task automatic test_load_wait();
    int idx = 0;
    q.push_back({RUN,            O_IDLE});
    q.push_back({RUN | IMR,      O_F});
    q.push_back({RUN,            O_D});
    q.push_back({RUN | LD,       O_E});
    q.push_back({RUN | LD,       O_M});
    q.push_back({RUN | LD,       O_M});
    q.push_back({RUN | LD,       O_M});
    q.push_back({RUN | LD | DMR, O_M});
    q.push_back({RUN | HLT | LD, O_W});
    q.push_back({7'b0,           O_IDLE});
    while (q.size() > 0) begin
      c = q.pop_front();
      {run, halt_req, imem_ready, dmem_ready, is_load, is_store, do_reg_write} = c.in;
      #2;
      n_total++;
      if (obs !== c.exp) begin
        n_bad++;
        $display("FAIL load_wait cyc%0d: got %b want %b", idx, obs, c.exp);
      end
      idx++;
      @(posedge clock); #1;
    end
    n_total++;
    if (instr_count !== 32'd3) begin
      n_bad++;
      $display("FAIL load_wait_count: got %0d want 3", instr_count);
    end
  endtask

  task automatic test_store_halt();
    int idx = 0;
    q.push_back({RUN,                  O_IDLE});
    q.push_back({RUN | IMR,            O_F});
    q.push_back({RUN,                  O_D});
    q.push_back({RUN | HLT | ST,       O_E});
    q.push_back({RUN | HLT | ST | DMR, O_MR});
    q.push_back({RUN | HLT,            O_IDLE});
    q.push_back({RUN,                  O_IDLE});
    q.push_back({RUN | IMR,            O_F});
    q.push_back({RUN,                  O_D});
    q.push_back({RUN | HLT,            O_ER});
    q.push_back({7'b0,                 O_IDLE});
    while (q.size() > 0) begin
      c = q.pop_front();
      {run, halt_req, imem_ready, dmem_ready, is_load, is_store, do_reg_write} = c.in;
      #2;
      n_total++;
      if (obs !== c.exp) begin
        n_bad++;
        $display("FAIL store_halt cyc%0d: got %b want %b", idx, obs, c.exp);
      end
      idx++;
      @(posedge clock); #1;
    end
    n_total++;
    if (instr_count !== 32'd5) begin
      n_bad++;
      $display("FAIL store_halt_count: got %0d want 5", instr_count);
    end
  endtask

  // Load+store decodes as a load; stray readies outside their wait state are ignored.
  task automatic test_back_to_back();
    int idx = 0;
    q.push_back({RUN,                  O_IDLE});
    q.push_back({RUN | IMR | DMR,      O_F});
    q.push_back({RUN | IMR | DMR,      O_D});
    q.push_back({RUN | IMR | LD | ST,  O_E});
    q.push_back({RUN | DMR | LD | ST,  O_M});
    q.push_back({RUN | LD | ST,        O_W});
    q.push_back({RUN | IMR,            O_F});
    q.push_back({RUN,                  O_D});
    q.push_back({RUN | WR | DMR,       O_E});
    q.push_back({RUN | HLT | WR,       O_W});
    q.push_back({7'b0,                 O_IDLE});
    while (q.size() > 0) begin
      c = q.pop_front();
      {run, halt_req, imem_ready, dmem_ready, is_load, is_store, do_reg_write} = c.in;
      #2;
      n_total++;
      if (obs !== c.exp) begin
        n_bad++;
        $display("FAIL back_to_back cyc%0d: got %b want %b", idx, obs, c.exp);
      end
      idx++;
      @(posedge clock); #1;
    end
    n_total++;
    if (instr_count !== 32'd7) begin
      n_bad++;
      $display("FAIL back_to_back_count: got %0d want 7", instr_count);
    end
  endtask

  task automatic test_reset_mid();
    int idx = 0;
    q.push_back({RUN,       O_IDLE});
    q.push_back({RUN | IMR, O_F});
    q.push_back({RUN,       O_D});
    q.push_back({RUN | WR,  O_E});
    q.push_back({RUN | WR,  O_W});
    while (q.size() > 0) begin
      c = q.pop_front();
      {run, halt_req, imem_ready, dmem_ready, is_load, is_store, do_reg_write} = c.in;
      #2;
      n_total++;
      if (obs !== c.exp) begin
        n_bad++;
        $display("FAIL reset_mid cyc%0d: got %b want %b", idx, obs, c.exp);
      end
      idx++;
      if (q.size() > 0) begin
        @(posedge clock); #1;
      end
    end
    #1 reset = 1'b1;
    #1;
    n_total++;
    if (obs !== O_IDLE) begin
      n_bad++;
      $display("FAIL reset_mid_outputs: got %b want %b", obs, O_IDLE);
    end
    n_total++;
    if (instr_count !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_count: got %0d want 0", instr_count);
    end
    {run, halt_req, imem_ready, dmem_ready, is_load, is_store, do_reg_write} = 7'b0;
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_wrap();
    int idx = 0;
    force dut.r_instr_count = {CountSize{1'b1}};
    @(posedge clock); #1;
    release dut.r_instr_count;
    q.push_back({RUN,       O_IDLE});
    q.push_back({RUN | IMR, O_F});
    q.push_back({RUN,       O_D});
    q.push_back({RUN | HLT, O_ER});
    while (q.size() > 0) begin
      c = q.pop_front();
      {run, halt_req, imem_ready, dmem_ready, is_load, is_store, do_reg_write} = c.in;
      #2;
      n_total++;
      if (obs !== c.exp) begin
        n_bad++;
        $display("FAIL wrap cyc%0d: got %b want %b", idx, obs, c.exp);
      end
      idx++;
      @(posedge clock); #1;
    end
    n_total++;
    if (instr_count !== '0) begin
      n_bad++;
      $display("FAIL wrap_count: got %0h want 0", instr_count);
    end
  endtask

  task automatic test_timeout();
    int idx = 0;
    q.push_back({RUN, O_IDLE});
    for (int i = 0; i < 4; i++) q.push_back({RUN, O_F});
    for (int i = 0; i < 3; i++) q.push_back({RUN | IMR | DMR, O_ERR});
    while (q.size() > 0) begin
      c = q.pop_front();
      {run, halt_req, imem_ready, dmem_ready, is_load, is_store, do_reg_write} = c.in;
      #2;
      n_total++;
      if (obs !== c.exp) begin
        n_bad++;
        $display("FAIL timeout cyc%0d: got %b want %b", idx, obs, c.exp);
      end
      idx++;
      @(posedge clock); #1;
    end
    {run, halt_req, imem_ready, dmem_ready, is_load, is_store, do_reg_write} = 7'b0;
    reset = 1'b1;
    #1;
    n_total++;
    if (obs !== O_IDLE) begin
      n_bad++;
      $display("FAIL timeout_reset: got %b want %b", obs, O_IDLE);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_no_writeback();
    test_load_wait();
    test_store_halt();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    test_timeout();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_stage_ctrl
